bf_program_loader: RTL and testbench
====================================

# bf_program_loader

Program loader for the brainfuck processor. It receives 8N1 UART bytes on `rx` while `loading` is high and filters out non-instruction characters. Each of the eight brainfuck characters is encoded to a 3-bit opcode and written sequentially into the program memory from address 0. It reports program length, overflow and bracket balance, and sits directly upstream of the processor core's instruction memory.

## Interface
- `INST_W`, 3: opcode width; must be ≥3.
- `ADDR_W`, 4: program memory address width; capacity 2^ADDR_W instructions.
- `CLKS_PER_BIT`, 10: sysClk cycles per UART bit; must be even and ≥4.
- `sysClk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `loading` in 1: high = load session active.
- `rx` in 1: UART line, idle high, 8N1, LSB first.
- `memWrEn` out 1: one-cycle program memory write strobe.
- `memAddr` out ADDR_W: write address.
- `memData` out INST_W: opcode to write.
- `progLen` out ADDR_W+1: number of instructions written this session.
- `loadDone` out 1: session closed and program committed.
- `overflow` out 1: sticky; an instruction was dropped because memory was full.
- `unbalanced` out 1: sticky; bracket mismatch detected.

## Operation
- `rx` is passed through a 2-flop synchronizer before any use.
- UART receive FSM has four states: IDLE, START, DATA, STOP.
  - IDLE→START when synchronized rx is low.
  - START waits CLKS_PER_BIT/2 cycles, then re-samples: low→DATA; high→IDLE (glitch rejected).
  - DATA samples 8 bits at CLKS_PER_BIT intervals, LSB first.
  - STOP samples once more. High: one-cycle `byteValid` pulse, then IDLE. Low: framing error; the byte is dropped and the FSM waits for rx high, then goes to IDLE.
- Opcode decode (package constants): `+`=0, `-`=1, `>`=2, `<`=3, `[`=4, `]`=5, `.`=6, `,`=7. All other bytes are ignored.
- `loading` is registered to `loading_q`.
- Rising edge (loading=1, loading_q=0): clear write pointer, progLen, depth, overflow, unbalanced, loadDone. A byteValid in the same cycle is discarded.
- On byteValid with a valid opcode while loading=1 and loading_q=1:
  - If pointer < 2^ADDR_W: write at the pointer, then increment pointer and progLen.
  - Otherwise: set overflow and do not write.
- byteValid while loading=0 is discarded. The UART keeps running.
- Falling edge (loading=0, loading_q=1): set loadDone. loadDone holds until the next rising edge.
- memAddr and memData hold their last written values between writes.

## Timing
- Reset value of every output is 0. FSM resets to IDLE; pointer and depth reset to 0.
- Reset mid-byte aborts the reception; no partial write occurs.
- byteValid occurs at the centre of the stop bit: 2 sync cycles + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT after the start falling edge.
- memWrEn, memAddr and memData are registered and asserted 1 cycle after byteValid, for exactly 1 cycle.
- progLen updates in the same cycle as memWrEn.
- loadDone rises 1 cycle after loading falls.
- A write and the falling edge cannot coincide, because writes require loading_q=1 and loading=1.

## Configuration
- Macro `BF_LOADER_BRACKET_CHECK_EN`.
- Defined:
  - Depth counter of ADDR_W+1 bits: `[` increments, `]` decrements.
  - `]` at depth 0 sets unbalanced and leaves depth at 0.
  - On the falling edge, depth≠0 sets unbalanced together with loadDone.
  - Opcodes dropped by overflow do not affect depth.
- Undefined: no depth counter; `unbalanced` is tied to 0.

## Structure
- Package `bf_pkg`: opcode constants `OP_INC`…`OP_IN`, their ASCII codes, and a decode function from byte to {valid, opcode}. It is shared with the processor core decoder.
- Sub-module `bf_uart_rx`: synchronizer, FSM and bit counters. Outputs `byteValid` and `byteData`. Parameter CLKS_PER_BIT.
- Top level contains the loading edge logic, pointer, flags and optional depth counter.

## Test plan
- Defaults. Send `+[.+]` with loading high, then drop loading → writes at addr 0–4 with data 0,4,6,0,5; loadDone=1, progLen=5, overflow=0, unbalanced=0.
- Send `a+ \n-` → exactly 2 writes (addr 0 data 0, addr 1 data 1); progLen=2.
- Send 17 `>` → 16 writes, addr 0–15 data 2. After the 17th byte: overflow=1, no write, progLen=16.
- With macro defined:
  - `]` → unbalanced=1 immediately.
  - New session `[[` then loading low → unbalanced=1 in the same cycle as loadDone.
  - Macro undefined, same stimulus → unbalanced=0.
- Start bit low for only 3 cycles → no byteValid. Full byte with stop bit low → no write, then the next good byte is written normally.
- Assert reset mid-byte → all outputs 0. Release, start a new session and send `,` → write at addr 0 data 7.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared brainfuck definitions: opcode encoding, ASCII source characters,
// byte-to-opcode decode, and the UART receiver state type.
package bf_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_INC  = 3'd0;
  localparam opcode_t OP_DEC  = 3'd1;
  localparam opcode_t OP_NEXT = 3'd2;
  localparam opcode_t OP_PREV = 3'd3;
  localparam opcode_t OP_JZ   = 3'd4;
  localparam opcode_t OP_JNZ  = 3'd5;
  localparam opcode_t OP_OUT  = 3'd6;
  localparam opcode_t OP_IN   = 3'd7;

  localparam logic [7:0] CH_INC  = 8'h2B; // '+'
  localparam logic [7:0] CH_DEC  = 8'h2D; // '-'
  localparam logic [7:0] CH_NEXT = 8'h3E; // '>'
  localparam logic [7:0] CH_PREV = 8'h3C; // '<'
  localparam logic [7:0] CH_JZ   = 8'h5B; // '['
  localparam logic [7:0] CH_JNZ  = 8'h5D; // ']'
  localparam logic [7:0] CH_OUT  = 8'h2E; // '.'
  localparam logic [7:0] CH_IN   = 8'h2C; // ','

  typedef struct packed {
    logic    valid;
    opcode_t op;
  } dec_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  function automatic dec_t bfDecode(input logic [7:0] ch);
    dec_t d;
    d.valid = 1'b1;
    d.op    = OP_INC;
    case (ch)
      CH_INC:  d.op = OP_INC;
      CH_DEC:  d.op = OP_DEC;
      CH_NEXT: d.op = OP_NEXT;
      CH_PREV: d.op = OP_PREV;
      CH_JZ:   d.op = OP_JZ;
      CH_JNZ:  d.op = OP_JNZ;
      CH_OUT:  d.op = OP_OUT;
      CH_IN:   d.op = OP_IN;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bf_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit glitch rejection,
// mid-bit sampling, framing-error drop. Emits a one-cycle byteValid.
module bf_uart_rx
  import bf_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       sysClk,
  input  logic       reset,
  input  logic       rx,
  output logic       byteValid,
  output logic [7:0] byteData
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rxState_t         state, stateNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic [2:0]       bitIdx, bitNxt;
  logic [7:0]       shReg, shNxt, dataNxt;
  logic             frameErr, errNxt, vldNxt;
  logic             rxMeta, rxSync;

  // Line idles high, so the synchronizer resets high to avoid a false start.
  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxSync <= rxMeta;
    end
  end

  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bitIdx    <= '0;
      shReg     <= '0;
      frameErr  <= 1'b0;
      byteValid <= 1'b0;
      byteData  <= '0;
    end else begin
      state     <= stateNxt;
      cnt       <= cntNxt;
      bitIdx    <= bitNxt;
      shReg     <= shNxt;
      frameErr  <= errNxt;
      byteValid <= vldNxt;
      byteData  <= dataNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    bitNxt   = bitIdx;
    shNxt    = shReg;
    errNxt   = frameErr;
    vldNxt   = 1'b0;
    dataNxt  = byteData;
    case (state)
      RX_IDLE: begin
        cntNxt = '0;
        errNxt = 1'b0;
        if (!rxSync) stateNxt = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_M1) begin
          cntNxt   = '0;
          bitNxt   = '0;
          stateNxt = rxSync ? RX_IDLE : RX_DATA;
        end else cntNxt = cnt + 1'b1;
      end
      RX_DATA: begin
        if (cnt == FULL_M1) begin
          cntNxt = '0;
          shNxt  = {rxSync, shReg[7:1]};
          bitNxt = bitIdx + 3'd1;
          if (bitIdx == 3'd7) stateNxt = RX_STOP;
        end else cntNxt = cnt + 1'b1;
      end
      RX_STOP: begin
        // After a bad stop bit, hold here until the line returns high.
        if (frameErr) begin
          if (rxSync) stateNxt = RX_IDLE;
        end else if (cnt == FULL_M1) begin
          cntNxt = '0;
          if (rxSync) begin
            vldNxt   = 1'b1;
            dataNxt  = shReg;
            stateNxt = RX_IDLE;
          end else errNxt = 1'b1;
        end else cntNxt = cnt + 1'b1;
      end
      default: stateNxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/bf_program_loader.sv
// Brainfuck program loader: filters UART bytes into opcodes and writes them
// sequentially to program memory. Bracket checking under BF_LOADER_BRACKET_CHECK_EN.
module bf_program_loader
  import bf_pkg::*;
#(
  parameter int INST_W       = 3,
  parameter int ADDR_W       = 4,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic              sysClk,
  input  logic              reset,
  input  logic              loading,
  input  logic              rx,
  output logic              memWrEn,
  output logic [ADDR_W-1:0] memAddr,
  output logic [INST_W-1:0] memData,
  output logic [ADDR_W:0]   progLen,
  output logic              loadDone,
  output logic              overflow,
  output logic              unbalanced
);

  localparam logic [ADDR_W:0] CAP = (ADDR_W + 1)'(1 << ADDR_W);

  logic            byteValid;
  logic [7:0]      byteData;
  logic            loadingQ, rise, fall, accept, room;
  logic [ADDR_W:0] ptr;
  dec_t            dec;

  bf_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) uRx (
    .sysClk    (sysClk),
    .reset     (reset),
    .rx        (rx),
    .byteValid (byteValid),
    .byteData  (byteData)
  );

  assign dec     = bfDecode(byteData);
  assign rise    = loading & ~loadingQ;
  assign fall    = ~loading & loadingQ;
  // loadingQ gating also discards a byte landing on the session's first cycle.
  assign accept  = byteValid & dec.valid & loading & loadingQ;
  assign room    = ptr < CAP;
  assign progLen = ptr;

  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      loadingQ <= 1'b0;
      ptr      <= '0;
      memWrEn  <= 1'b0;
      memAddr  <= '0;
      memData  <= '0;
      loadDone <= 1'b0;
      overflow <= 1'b0;
    end else begin
      loadingQ <= loading;
      memWrEn  <= 1'b0;
      if (rise) begin
        ptr      <= '0;
        overflow <= 1'b0;
        loadDone <= 1'b0;
      end else begin
        if (fall) loadDone <= 1'b1;
        if (accept) begin
          if (room) begin
            memWrEn <= 1'b1;
            memAddr <= ptr[ADDR_W-1:0];
            memData <= INST_W'(dec.op);
            ptr     <= ptr + 1'b1;
          end else overflow <= 1'b1;
        end
      end
    end
  end

`ifdef BF_LOADER_BRACKET_CHECK_EN
  logic [ADDR_W:0] depth;
  logic            unbalancedQ;

  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      depth       <= '0;
      unbalancedQ <= 1'b0;
    end else if (rise) begin
      depth       <= '0;
      unbalancedQ <= 1'b0;
    end else begin
      if (fall && depth != '0) unbalancedQ <= 1'b1;
      // Only committed opcodes move the depth; overflow drops are ignored.
      if (accept && room) begin
        if (dec.op == OP_JZ) depth <= depth + 1'b1;
        else if (dec.op == OP_JNZ) begin
          if (depth == '0) unbalancedQ <= 1'b1;
          else depth <= depth - 1'b1;
        end
      end
    end
  end

  assign unbalanced = unbalancedQ;
`else
  assign unbalanced = 1'b0;
`endif

endmodule

// File: tb/tb_bf_program_loader.sv
// Scoreboard bench for bf_program_loader: UART byte stimulus, expected writes
// queued at send time and popped on each memWrEn.
module tb_bf_program_loader;

  localparam int CPB = 10;
`ifdef BF_LOADER_BRACKET_CHECK_EN
  localparam int BRK = 1;
`else
  localparam int BRK = 0;
`endif

  logic       sysClk, reset, loading, rx;
  logic       memWrEn, loadDone, overflow, unbalanced;
  logic [3:0] memAddr;
  logic [2:0] memData;
  logic [4:0] progLen;

  typedef struct {int addr; int data; int len;} wr_t;
  wr_t sb[$];
  wr_t w;
  int  mPtr;
  int  nTests, nFail;

  bf_program_loader #(.INST_W(3), .ADDR_W(4), .CLKS_PER_BIT(CPB)) dut (
    .sysClk     (sysClk),
    .reset      (reset),
    .loading    (loading),
    .rx         (rx),
    .memWrEn    (memWrEn),
    .memAddr    (memAddr),
    .memData    (memData),
    .progLen    (progLen),
    .loadDone   (loadDone),
    .overflow   (overflow),
    .unbalanced (unbalanced)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  task automatic chk(input string tag, input int obs, input int exp);
    nTests++;
    if (obs != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int opOf(input byte c);
    case (c)
      "+": return 0;
      "-": return 1;
      ">": return 2;
      "<": return 3;
      "[": return 4;
      "]": return 5;
      ".": return 6;
      ",": return 7;
      default: return -1;
    endcase
  endfunction

  always @(negedge sysClk) begin
    if (reset && memWrEn) begin
      if (sb.size() == 0) chk("unexpWr", 1, 0);
      else begin
        w = sb.pop_front();
        chk("wrAddr", int'(memAddr), w.addr);
        chk("wrData", int'(memData), w.data);
        chk("wrLen", int'(progLen), w.len);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  task automatic sendByte(input byte b, input bit stopv);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stopv;
    idle(CPB);
    rx = 1'b1;
    idle(4);
  endtask

  task automatic sendCh(input byte c);
    int o;
    o = opOf(c);
    if (loading && o >= 0 && mPtr < 16) begin
      sb.push_back('{mPtr, o, mPtr + 1});
      mPtr++;
    end
    sendByte(c, 1'b1);
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++) sendCh(s[i]);
  endtask

  task automatic startSession();
    loading = 1'b1;
    mPtr = 0;
    idle(3);
    chk("startDone", int'(loadDone), 0);
    chk("startLen", int'(progLen), 0);
  endtask

  task automatic endSession(input int expUnb);
    chk("sbDrain", sb.size(), 0);
    loading = 1'b0;
    chk("preDone", int'(loadDone), 0);
    idle(1);
    chk("loadDone", int'(loadDone), 1);
    chk("endUnb", int'(unbalanced), expUnb);
  endtask

  initial begin
    nTests = 0; nFail = 0; mPtr = 0;
    reset = 1'b0; loading = 1'b0; rx = 1'b1;
    idle(3);
    chk("rstWrEn", int'(memWrEn), 0);
    chk("rstAddr", int'(memAddr), 0);
    chk("rstData", int'(memData), 0);
    chk("rstLen", int'(progLen), 0);
    chk("rstDone", int'(loadDone), 0);
    chk("rstOvf", int'(overflow), 0);
    chk("rstUnb", int'(unbalanced), 0);
    reset = 1'b1;
    idle(3);

    startSession();
    sendStr("+[.+]");
    endSession(0);
    chk("len5", int'(progLen), 5);
    chk("ovf5", int'(overflow), 0);

    startSession();
    sendStr("a+ \n-");
    endSession(0);
    chk("len2", int'(progLen), 2);

    startSession();
    for (int i = 0; i < 17; i++) begin
      sendCh(">");
      if (i == 15) chk("ovfAt16", int'(overflow), 0);
    end
    chk("ovfAt17", int'(overflow), 1);
    chk("len16", int'(progLen), 16);
    endSession(0);

    startSession();
    sendCh("]");
    chk("unbClose", int'(unbalanced), BRK);
    endSession(BRK);

    startSession();
    sendStr("[[");
    chk("unbOpen", int'(unbalanced), 0);
    endSession(BRK);

    startSession();
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(20);
    chk("glitchLen", int'(progLen), 0);
    sendByte("+", 1'b0);
    chk("frameLen", int'(progLen), 0);
    sendCh("-");
    chk("goodLen", int'(progLen), 1);
    endSession(0);

    startSession();
    rx = 1'b0;
    idle(CPB + CPB / 2);
    rx = 1'b1;
    idle(CPB);
    reset = 1'b0;
    loading = 1'b0;
    idle(2);
    chk("midWrEn", int'(memWrEn), 0);
    chk("midAddr", int'(memAddr), 0);
    chk("midData", int'(memData), 0);
    chk("midLen", int'(progLen), 0);
    chk("midDone", int'(loadDone), 0);
    chk("midOvf", int'(overflow), 0);
    chk("midUnb", int'(unbalanced), 0);
    reset = 1'b1;
    idle(3 * CPB);
    startSession();
    sendCh(",");
    chk("postRstLen", int'(progLen), 1);
    endSession(0);

    idle(5);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
